// File: rtl/cordic_sequencer.sv
// cordic_sequencer: reduces [-pi, pi) angles into the CORDIC core's
// convergent range, runs the core's level-held start/done handshake, and
// returns quadrant-corrected cos/sin with the measured core latency.
// Optional build macro: CORDIC_SEQ_SAT_EN (saturating result negation).
module cordic_sequencer #(
  parameter int BIT_WIDTH = 16,
  parameter int LAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_angle,
  output logic                 core_start,
  output logic [BIT_WIDTH-1:0] core_angle,
  input  logic                 core_ready,
  input  logic                 core_done,
  input  logic [BIT_WIDTH-1:0] core_cos,
  input  logic [BIT_WIDTH-1:0] core_sin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_cos,
  output logic [BIT_WIDTH-1:0] out_sin,
  output logic [LAT_WIDTH-1:0] out_latency
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_OUT} state_t;

  state_t               state_q, state_d;
  logic                 flip_q, flip_d;
  logic                 core_start_q, core_start_d;
  logic [BIT_WIDTH-1:0] core_angle_q, core_angle_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] out_cos_q, out_cos_d;
  logic [BIT_WIDTH-1:0] out_sin_q, out_sin_d;
  logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_WIDTH-1:0] out_latency_q, out_latency_d;

  logic                 in_flip;
  logic [BIT_WIDTH-1:0] in_reduced;

  // Two's complement negation; the most negative value either wraps or clamps.
  function automatic logic [BIT_WIDTH-1:0] negate(input logic [BIT_WIDTH-1:0] x);
`ifdef CORDIC_SEQ_SAT_EN
    if (x == {1'b1, {(BIT_WIDTH-1){1'b0}}})
      return {1'b0, {(BIT_WIDTH-1){1'b1}}};
    else
      return ~x + 1'b1;
`else
    return ~x + 1'b1;
`endif
  endfunction

  // Quadrant II/III (and exactly +pi/2) are rotated by pi into the core's range.
  always_comb begin
    in_flip    = in_angle[BIT_WIDTH-1] ^ in_angle[BIT_WIDTH-2];
    in_reduced = {in_angle[BIT_WIDTH-1] ^ in_flip, in_angle[BIT_WIDTH-2:0]};
  end

  // Accept only when idle and the core sits in its init state; never during reset.
  always_comb begin
    in_ready = (state_q == S_IDLE) && core_ready && !reset;
  end

  // Next-state and registered-output logic for the one-in-flight sequencer.
  always_comb begin
    state_d       = state_q;
    flip_d        = flip_q;
    core_start_d  = core_start_q;
    core_angle_d  = core_angle_q;
    out_valid_d   = out_valid_q;
    out_cos_d     = out_cos_q;
    out_sin_d     = out_sin_q;
    lat_cnt_d     = lat_cnt_q;
    out_latency_d = out_latency_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          core_angle_d = in_reduced;
          flip_d       = in_flip;
          lat_cnt_d    = '0;
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_done) begin
          out_cos_d     = flip_q ? negate(core_cos) : core_cos;
          out_sin_d     = flip_q ? negate(core_sin) : core_sin;
          out_latency_d = lat_cnt_q;
          core_start_d  = 1'b0;
          state_d       = S_RELEASE;
        end else if (lat_cnt_q != '1) begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!core_done && core_ready) begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by the shared reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      flip_q        <= 1'b0;
      core_start_q  <= 1'b0;
      core_angle_q  <= '0;
      out_valid_q   <= 1'b0;
      out_cos_q     <= '0;
      out_sin_q     <= '0;
      lat_cnt_q     <= '0;
      out_latency_q <= '0;
    end else begin
      state_q       <= state_d;
      flip_q        <= flip_d;
      core_start_q  <= core_start_d;
      core_angle_q  <= core_angle_d;
      out_valid_q   <= out_valid_d;
      out_cos_q     <= out_cos_d;
      out_sin_q     <= out_sin_d;
      lat_cnt_q     <= lat_cnt_d;
      out_latency_q <= out_latency_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_angle  = core_angle_q;
  assign out_valid   = out_valid_q;
  assign out_cos     = out_cos_q;
  assign out_sin     = out_sin_q;
  assign out_latency = out_latency_q;

endmodule
